// File: rtl/sseg_display_driver.sv
// Four-digit multiplexed seven-segment driver with hex display and a
// sequential double-dabble binary-to-BCD path for decimal display.
module sseg_display_driver #(
  parameter int REFRESH_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        load,
  input  logic        dec_mode,
  output logic        busy,
  output logic        overflow,
  output logic [6:0]  Segments,
  output logic [3:0]  Anodes
);

  localparam logic [15:0] LAST    = 16'(REFRESH_CYCLES - 1);
  localparam logic [6:0]  DASH    = 7'b0111111;
  localparam logic [15:0] DEC_MAX = 16'd9999;

  typedef enum logic {S_IDLE, S_CONV} state_t;

  state_t           state;
  logic [3:0][3:0]  digits, digits_nxt;
  logic [1:0]       idx, idx_nxt;
  logic [15:0]      rcnt;
  logic [31:0]      sr, sr_adj, sr_nxt;
  logic [3:0]       step;
  logic             ovf_nxt, accept;

  // Active-low {g..a} glyphs for hex digits.
  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'h0:    glyph = 7'b1000000;
      4'h1:    glyph = 7'b1111001;
      4'h2:    glyph = 7'b0100100;
      4'h3:    glyph = 7'b0110000;
      4'h4:    glyph = 7'b0011001;
      4'h5:    glyph = 7'b0010010;
      4'h6:    glyph = 7'b0000010;
      4'h7:    glyph = 7'b1111000;
      4'h8:    glyph = 7'b0000000;
      4'h9:    glyph = 7'b0010000;
      4'hA:    glyph = 7'b0001000;
      4'hB:    glyph = 7'b0000011;
      4'hC:    glyph = 7'b1000110;
      4'hD:    glyph = 7'b0100001;
      4'hE:    glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
  endfunction

  // Add-3 correction on every BCD nibble before the shift.
  generate
    for (genvar n = 0; n < 4; n++) begin : g_adj
      assign sr_adj[16+4*n +: 4] = (sr[16+4*n +: 4] >= 4'd5) ?
                                   sr[16+4*n +: 4] + 4'd3 : sr[16+4*n +: 4];
    end
  endgenerate
  assign sr_adj[15:0] = sr[15:0];
  assign sr_nxt       = sr_adj << 1;

  // Next digit/overflow/index values; segments are rendered from these so
  // the registered Segments always matches the registered Anodes.
  always_comb begin
    accept     = load & (state == S_IDLE);
    digits_nxt = digits;
    ovf_nxt    = overflow;
    if (accept && !dec_mode) begin
      digits_nxt = value;
      ovf_nxt    = 1'b0;
    end else if (accept && dec_mode && value > DEC_MAX) begin
      ovf_nxt    = 1'b1;
    end else if (state == S_CONV && step == 4'd15) begin
      digits_nxt = sr_nxt[31:16];
      ovf_nxt    = 1'b0;
    end
    idx_nxt = (rcnt == LAST) ? idx + 2'd1 : idx;
  end

  // Scan counter, digit registers and registered display outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rcnt     <= '0;
      idx      <= '0;
      digits   <= '0;
      overflow <= 1'b0;
      Segments <= 7'b1000000;
      Anodes   <= 4'b1110;
    end else begin
      rcnt     <= (rcnt == LAST) ? '0 : rcnt + 16'd1;
      idx      <= idx_nxt;
      digits   <= digits_nxt;
      overflow <= ovf_nxt;
      Segments <= ovf_nxt ? DASH : glyph(digits_nxt[idx_nxt]);
      Anodes   <= ~(4'b0001 << idx_nxt);
    end
  end

  // Conversion FSM: one adjust-and-shift step per cycle for 16 cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      sr    <= '0;
      step  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept && dec_mode && value <= DEC_MAX) begin
            state <= S_CONV;
            busy  <= 1'b1;
            sr    <= {16'd0, value};
            step  <= '0;
          end
        end
        S_CONV: begin
          sr   <= sr_nxt;
          step <= step + 4'd1;
          if (step == 4'd15) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sseg_display_driver.sv
// Scoreboard bench: stimulus pushes expected display states tagged with the
// cycle count since reset release; a negedge monitor pops and compares.
module tb_sseg_display_driver;

  localparam int R = 4;

  localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100,
                         G3 = 7'b0110000, G4 = 7'b0011001, G5 = 7'b0010010,
                         G9 = 7'b0010000, GA = 7'b0001000, GF = 7'b0001110,
                         GD = 7'b0111111;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = '0;
  logic        load = 1'b0;
  logic        dec_mode = 1'b0;
  logic        busy, overflow;
  logic [6:0]  Segments;
  logic [3:0]  Anodes;

  sseg_display_driver #(.REFRESH_CYCLES(R)) dut (
    .clk(clk), .reset(reset), .value(value), .load(load), .dec_mode(dec_mode),
    .busy(busy), .overflow(overflow), .Segments(Segments), .Anodes(Anodes)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         kk;
    logic [3:0] an;
    logic [6:0] seg;
    logic       bsy;
    logic       ovf;
    string      tag;
  } exp_t;

  exp_t q[$];
  int   k = 0;
  int   checks = 0;
  int   errors = 0;

  // Edges seen since reset release.
  always @(posedge clk or posedge reset)
    if (reset) k <= 0; else k <= k + 1;

  // Monitor: one-hot anode every cycle plus queued expectations.
  always @(negedge clk) begin
    exp_t e;
    checks++;
    if ($countones(~Anodes) != 1) begin
      errors++;
      $display("FAIL onehot k=%0d Anodes=%b", k, Anodes);
    end
    while (q.size() > 0 && q[0].kk <= k) begin
      e = q.pop_front();
      checks++;
      if (e.kk < k) begin
        errors++;
        $display("FAIL %s missed slot k=%0d now=%0d", e.tag, e.kk, k);
      end else if (Anodes !== e.an || Segments !== e.seg ||
                   busy !== e.bsy || overflow !== e.ovf) begin
        errors++;
        $display("FAIL %s k=%0d got an=%b seg=%b busy=%b ovf=%b want an=%b seg=%b busy=%b ovf=%b",
                 e.tag, k, Anodes, Segments, busy, overflow, e.an, e.seg, e.bsy, e.ovf);
      end
    end
  end

  task automatic push(input int kk, input logic [6:0] seg, input logic bsy,
                      input logic ovf, input string tag);
    exp_t e;
    e.kk = kk; e.an = ~(4'b0001 << ((kk / R) % 4));
    e.seg = seg; e.bsy = bsy; e.ovf = ovf; e.tag = tag;
    q.push_back(e);
  endtask

  // Expect n consecutive cycles from start; segs indexed by digit position.
  task automatic expect_scan(input int start, input int n,
                             input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3,
                             input logic bsy, input logic ovf, input string tag);
    logic [6:0] s [4];
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    for (int i = start; i < start + n; i++)
      push(i, s[(i / R) % 4], bsy, ovf, tag);
  endtask

  task automatic wait_k(input int t);
    int g = 0;
    while (k < t && g < 2000) begin
      @(posedge clk); #1;
      g++;
    end
    if (k < t) begin
      checks++; errors++;
      $display("FAIL timeout k=%0d want %0d", k, t);
    end
  endtask

  // Drive a one-cycle load from a posedge+1 point; returns k at issue.
  task automatic issue(input logic [15:0] v, input logic dm, output int kk);
    kk = k;
    value = v; dec_mode = dm; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  initial begin
    int kk;
    push(0, G0, 1'b0, 1'b0, "reset_state");
    @(negedge clk); @(negedge clk); #1;
    reset = 1'b0;

    // Idle scan after release.
    expect_scan(1, 16, G0, G0, G0, G0, 1'b0, 1'b0, "idle_scan");
    wait_k(16);

    // Hex A5F3.
    kk = k;
    expect_scan(kk + 1, 16, G3, GF, G5, GA, 1'b0, 1'b0, "hex_a5f3");
    issue(16'hA5F3, 1'b0, kk);
    wait_k(kk + 16);

    // Decimal 1234: old display held while busy, then 4,3,2,1.
    kk = k;
    expect_scan(kk + 1, 16, G3, GF, G5, GA, 1'b1, 1'b0, "dec1234_busy");
    expect_scan(kk + 17, 16, G4, G3, G2, G1, 1'b0, 1'b0, "dec1234_done");
    issue(16'd1234, 1'b1, kk);
    wait_k(kk + 32);

    // Decimal 10000 -> dashes and overflow.
    kk = k;
    expect_scan(kk + 1, 16, GD, GD, GD, GD, 1'b0, 1'b1, "dec_ovf");
    issue(16'd10000, 1'b1, kk);
    wait_k(kk + 16);

    // Hex 0000 clears overflow.
    kk = k;
    expect_scan(kk + 1, 16, G0, G0, G0, G0, 1'b0, 1'b0, "hex_0000");
    issue(16'h0000, 1'b0, kk);
    wait_k(kk + 16);

    // Decimal 9999 with a hex load on busy cycle 5 that must be ignored.
    kk = k;
    expect_scan(kk + 1, 16, G0, G0, G0, G0, 1'b1, 1'b0, "dec9999_busy");
    expect_scan(kk + 17, 16, G9, G9, G9, G9, 1'b0, 1'b0, "dec9999_done");
    issue(16'd9999, 1'b1, kk);
    wait_k(kk + 5);
    value = 16'hFFFF; dec_mode = 1'b0; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    wait_k(kk + 32);

    // Decimal 4321 aborted by reset on busy cycle 8.
    kk = k;
    expect_scan(kk + 1, 7, G9, G9, G9, G9, 1'b1, 1'b0, "dec4321_busy");
    issue(16'd4321, 1'b1, kk);
    wait_k(kk + 8);
    reset = 1'b1;
    push(0, G0, 1'b0, 1'b0, "abort_reset");
    @(negedge clk); @(negedge clk); #1;
    reset = 1'b0;
    expect_scan(1, 16, G0, G0, G0, G0, 1'b0, 1'b0, "post_abort");
    wait_k(16);

    // Hex 0042 after abort.
    kk = k;
    expect_scan(kk + 1, 16, G2, G4, G0, G0, 1'b0, 1'b0, "hex_0042");
    issue(16'h0042, 1'b0, kk);
    wait_k(kk + 17);
    @(negedge clk); #1;

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain left=%0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sseg_display_driver.md
SSEG_DISPLAY_DRIVER -- requirements
Module: sseg_display_driver

Interface
REQ-001 Parameter REFRESH_CYCLES, default 4: clock cycles each digit stays enabled; legal range 1..65535.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 value  input  16  number to display.
REQ-005 load  input  1  one-cycle strobe; captures value and dec_mode.
REQ-006 dec_mode  input  1  0 = hexadecimal display, 1 = decimal (BCD) display.
REQ-007 busy  output  1  high while a decimal conversion is in progress.
REQ-008 overflow  output  1  high while the display shows the decimal-overflow pattern.
REQ-009 Segments  output  7  cathodes, active-low; bit0 = a, bit1 = b, ... bit6 = g.
REQ-010 Anodes  output  4  digit enables, active-low; Anodes[0] = least-significant digit.

Function
REQ-011 Four 4-bit digit registers (D3..D0) SHALL hold the displayed code; Segments SHALL always render the digit currently selected by Anodes.
REQ-012 Glyphs: 0-9 and A-F use standard seven-segment shapes. Segment codes are active-low {g..a}. Examples: 0 = 7'b1000000, 1 = 7'b1111001, 8 = 7'b0000000, F = 7'b0001110. Dash = 7'b0111111.
REQ-013 Scan: the refresh counter counts 0..REFRESH_CYCLES-1. On wrap, the digit index advances 0->1->2->3->0.
REQ-014 Anodes SHALL equal ~(4'b0001 << index), with exactly one bit low in every cycle, including during and immediately after reset.
REQ-015 Segments and Anodes SHALL be registered and SHALL change on the same clock edge. No cycle may pair a new anode with old segments.
REQ-016 Hex load (load=1, dec_mode=0, busy=0): D3..D0 = value[15:12]..value[3:0] on the next edge (latency 1); overflow cleared on that edge; busy stays 0.
REQ-017 Decimal load with value <= 9999 (load=1, dec_mode=1, busy=0): start a sequential shift-add-3 (double-dabble) conversion.
  - busy = 1 from the next edge for exactly 16 cycles.
  - On the edge where busy falls, D3..D0 take the BCD thousands..units and overflow is cleared.
REQ-018 During a conversion, D3..D0 and overflow SHALL hold their previous contents, and scanning SHALL continue undisturbed.
REQ-019 Decimal load with value > 9999: no conversion runs; busy stays 0.
  - On the next edge, all four digits display dash and overflow = 1.
  - This persists until the next accepted load.
REQ-020 load asserted while busy = 1 SHALL be ignored entirely (value/dec_mode not captured, conversion unaffected).
REQ-021 load is level-sampled per cycle: a load held high for N cycles with busy=0 is accepted on every cycle in hex mode. In decimal mode, only the first cycle is accepted, because busy then blocks the rest.
REQ-022 The refresh counter and digit index SHALL NOT be reset or resynchronised by load.
REQ-023 Width rules:
  - The conversion shift register is 16 + 16 bits wide.
  - Each BCD nibble >= 5 gets +3 before each shift.
  - No truncation is permitted for inputs 0..9999.

Reset
REQ-024 While reset = 1, all of the following hold asynchronously:
  - D3..D0 = 0; digit index = 0; refresh counter = 0.
  - busy = 0; overflow = 0.
  - Anodes = 4'b1110; Segments = 7'b1000000.
REQ-025 Reset asserted mid-conversion SHALL abort the conversion; after release the block idles with the REQ-024 values.
REQ-026 The first scan advance after reset release occurs REFRESH_CYCLES edges after release.

Verification
REQ-027 Reset release with REFRESH_CYCLES=4, no load -> Anodes cycles 1110,1101,1011,0111, 4 cycles each. Segments = 7'b1000000 on every digit. Exactly one anode low in every cycle.
REQ-028 Hex load value=16'hA5F3 -> one edge later, across a full scan: digit0 shows 3, digit1 shows F, digit2 shows 5, digit3 shows A. busy = 0 throughout.
REQ-029 Decimal load value=16'd1234 -> busy high for exactly 16 cycles while the display holds its old digits. Then digits read 4,3,2,1 (digit0..digit3) and overflow = 0.
REQ-030 Decimal load value=16'd10000 -> next edge: all digits show 7'b0111111, overflow = 1, busy = 0. A following hex load 16'h0000 clears overflow and shows 0000.
REQ-031 Decimal load 16'd9999, then a hex load 16'hFFFF on cycle 5 of busy -> the hex load is ignored; final display 9999.
REQ-032 Reset pulse on cycle 8 of a decimal conversion of 16'd4321 -> busy drops immediately, display = 0000, Anodes = 1110. A subsequent hex load 16'h0042 displays 0042.
